bus_arbiter: RTL and testbench

- Shares the single CPU-side port of the 8-bit Wishbone bus front-end (en/op/addr/data/busy) between NREQ requesters, e.g. CPU instruction fetch, CPU load/store and a DMA engine.
- Grants one requester at a time, latches its request and sequences the downstream enable so exactly one bus transaction runs per grant.
- Returns read data and a done pulse to the owner.

---
 rtl/bus_arbiter_pkg.sv | 20 ++
 rtl/bus_arbiter_pick.sv | 30 +++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: BUSOP codes and arbiter state encodings.
package bus_arbiter_pkg;

  localparam logic [2:0] BUSOP_READB  = 3'd0;
  localparam logic [2:0] BUSOP_READH  = 3'd1;
  localparam logic [2:0] BUSOP_READW  = 3'd2;
  localparam logic [2:0] BUSOP_READBU = 3'd3;
  localparam logic [2:0] BUSOP_READHU = 3'd4;
  localparam logic [2:0] BUSOP_WRITEB = 3'd5;
  localparam logic [2:0] BUSOP_WRITEH = 3'd6;
  localparam logic [2:0] BUSOP_WRITEW = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational NREQ-way priority picker; the search begins at the start index and wraps.
module arb_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] start,
  output logic [NREQ-1:0] grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = (int'(start) + k) % int'(NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates NREQ requesters onto the single CPU-side bus port, one transaction per grant.
// Define ARB_ROUNDROBIN_EN for rotating priority; otherwise index 0 has fixed highest priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NREQ-1:0]     I_req_en,
  input  logic [3*NREQ-1:0]   I_req_op,
  input  logic [32*NREQ-1:0]  I_req_addr,
  input  logic [32*NREQ-1:0]  I_req_data,
  output logic [NREQ-1:0]     O_req_grant,
  output logic [NREQ-1:0]     O_req_done,
  output logic [31:0]         O_req_data,
  output logic                O_bus_en,
  output logic [2:0]          O_bus_op,
  output logic [31:0]         O_bus_addr,
  output logic [31:0]         O_bus_data,
  input  logic [31:0]         I_bus_data,
  input  logic                I_bus_busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, done_q;
  logic [31:0]     rdata_q, addr_q, data_q;
  logic [2:0]      op_q;
  logic            bus_en;

  logic [NREQ-1:0] pick_grant;
  logic [IdxW-1:0] pick_idx, start_idx;
  logic            pick_any;
  int unsigned     win;

  assign win = 32'(pick_idx);

`ifdef ARB_ROUNDROBIN_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ptr_q <= IdxW'(NREQ - 1);
    end else if (state_q == ARB_IDLE && pick_any) begin
      ptr_q <= pick_idx;
    end
  end

  assign start_idx = (ptr_q == IdxW'(NREQ - 1)) ? '0 : ptr_q + 1'b1;
`else
  assign start_idx = '0;
`endif

  arb_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_pick (
    .req   (I_req_en),
    .start (start_idx),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    bus_en  = 1'b0;
    case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        bus_en  = 1'b1;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Enable follows busy so it is already low when busy falls; no restart downstream.
        bus_en = I_bus_busy;
        if (!I_bus_busy) state_d = ARB_DONE;
      end
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_grant;
            op_q    <= I_req_op[3*win +: 3];
            addr_q  <= I_req_addr[32*win +: 32];
            data_q  <= I_req_data[32*win +: 32];
          end
        end
        ARB_WAIT: begin
          if (!I_bus_busy) begin
            done_q  <= grant_q;
            rdata_q <= I_bus_data;
          end
        end
        ARB_DONE: grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign O_req_grant = grant_q;
  assign O_req_done  = done_q;
  assign O_req_data  = rdata_q;
  assign O_bus_en    = bus_en;
  assign O_bus_op    = op_q;
  assign O_bus_addr  = addr_q;
  assign O_bus_data  = data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a simple busy-counting downstream model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_en;
  logic [5:0]  req_op;
  logic [63:0] req_addr, req_data;
  logic [1:0]  grant, done;
  logic [31:0] req_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_op;
  logic        bus_en, bus_busy;

  int lat = 1;
  int busy_cnt;
  int starts = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(2)) dut (
    .CLK_I       (clk),
    .RST_I       (rst_n),
    .I_req_en    (req_en),
    .I_req_op    (req_op),
    .I_req_addr  (req_addr),
    .I_req_data  (req_data),
    .O_req_grant (grant),
    .O_req_done  (done),
    .O_req_data  (req_rdata),
    .O_bus_en    (bus_en),
    .O_bus_op    (bus_op),
    .O_bus_addr  (bus_addr),
    .O_bus_data  (bus_wdata),
    .I_bus_data  (bus_rdata),
    .I_bus_busy  (bus_busy)
  );

  // Downstream: an enable seen while idle starts a transaction that stays busy for lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (bus_en) begin
      busy_cnt <= lat;
      starts   <= starts + 1;
    end
  end
  assign bus_busy = (busy_cnt != 0);

  task automatic do_reset();
    rst_n  = 1'b0;
    req_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_en = '0; req_op = '0; req_addr = '0; req_data = '0; bus_rdata = '0;
    rst_n = 1'b0;
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b exp 00", grant); end
    tests++; if (done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b exp 00", done); end
    tests++; if (req_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", req_rdata); end
    tests++; if (bus_en !== 1'b0) begin fails++; $display("FAIL reset_bus_en: got %b exp 0", bus_en); end
    tests++; if (bus_op !== 3'd0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_bus_fields: got %h/%h/%h exp 0", bus_op, bus_addr, bus_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int s0, en_cnt, done_cnt, done_cyc;
    lat = 5; bus_rdata = 32'hDEADBEEF;
    req_op[2:0] = BUSOP_READW; req_addr[31:0] = 32'h100;
    req_en[0] = 1'b1;
    s0 = starts; en_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rd_grant: got %b exp 01", grant); end
        tests++; if (bus_op !== BUSOP_READW || bus_addr !== 32'h100) begin
          fails++; $display("FAIL rd_fields: got %h/%h exp 2/100", bus_op, bus_addr);
        end
      end
      if (c == 7) begin
        tests++; if (bus_en !== 1'b0 || bus_busy !== 1'b0) begin
          fails++; $display("FAIL rd_en_drop: got en=%b busy=%b exp 0/0", bus_en, bus_busy);
        end
      end
      if (bus_en) en_cnt++;
      if (done[0]) begin done_cnt++; done_cyc = c; req_en[0] = 1'b0; end
    end
    tests++; if (en_cnt != 6) begin fails++; $display("FAIL rd_en_cycles: got %0d exp 6", en_cnt); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rd_done_count: got %0d exp 1", done_cnt); end
    tests++; if (done_cyc != 8) begin fails++; $display("FAIL rd_done_cycle: got %0d exp 8", done_cyc); end
    tests++; if (req_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h exp deadbeef", req_rdata); end
    tests++; if (starts - s0 != 1) begin fails++; $display("FAIL rd_issue_count: got %0d exp 1", starts - s0); end
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rd_grant_clear: got %b exp 00", grant); end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  prev, ord[2];
    logic [31:0] adr[2];
    logic [2:0]  opc[2];
    int n, d0, d1;
    do_reset();
    lat = 2; bus_rdata = 32'h11223344;
    req_op = {BUSOP_READB, BUSOP_READW};
    req_addr = {32'h2000, 32'h1000};
    req_en = 2'b11;
    prev = '0; n = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 40 && (d0 + d1) < 2; c++) begin
      @(posedge clk); #1;
      if (prev == 2'b00 && grant != 2'b00 && n < 2) begin
        ord[n] = grant; adr[n] = bus_addr; opc[n] = bus_op; n++;
      end
      prev = grant;
      if (done[0]) begin d0++; req_en[0] = 1'b0; end
      if (done[1]) begin d1++; req_en[1] = 1'b0; end
    end
    tests++; if (n != 2 || d0 != 1 || d1 != 1) begin
      fails++; $display("FAIL sim_counts: got grants=%0d d0=%0d d1=%0d exp 2/1/1", n, d0, d1);
    end
    if (n == 2) begin
      tests++; if (ord[0] !== 2'b01 || ord[1] !== 2'b10) begin
        fails++; $display("FAIL sim_order: got %b,%b exp 01,10", ord[0], ord[1]);
      end
      tests++; if (adr[0] !== 32'h1000 || adr[1] !== 32'h2000) begin
        fails++; $display("FAIL sim_addr: got %h,%h exp 1000,2000", adr[0], adr[1]);
      end
      tests++; if (opc[0] !== BUSOP_READW || opc[1] !== BUSOP_READB) begin
        fails++; $display("FAIL sim_op: got %0d,%0d exp 2,0", opc[0], opc[1]);
      end
    end
  endtask

  task automatic test_starvation();
    logic [1:0] prev, ord[4], exp_ord[4];
    int n, d0, d1;
`ifdef ARB_ROUNDROBIN_EN
    exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_ord = '{2'b01, 2'b01, 2'b10, 2'b10};
`endif
    do_reset();
    lat = 1;
    req_addr = {32'h2200, 32'h1100};
    req_en = 2'b11;
    prev = '0; n = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 80 && (d0 + d1) < 4; c++) begin
      @(posedge clk); #1;
      if (prev == 2'b00 && grant != 2'b00 && n < 4) begin ord[n] = grant; n++; end
      prev = grant;
      if (done[0]) begin d0++; if (d0 == 2) req_en[0] = 1'b0; end
      if (done[1]) begin d1++; if (d1 == 2) req_en[1] = 1'b0; end
    end
    req_en = '0;
    tests++; if (n != 4) begin fails++; $display("FAIL starve_grants: got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        tests++; if (ord[i] !== exp_ord[i]) begin
          fails++; $display("FAIL starve_order[%0d]: got %b exp %b", i, ord[i], exp_ord[i]);
        end
      end
    end
  endtask

  task automatic test_write_passthrough();
    bit changed, seen_done;
    lat = 3; bus_rdata = 32'h55AA55AA;
    repeat (2) @(posedge clk);
    #1;
    req_op[5:3] = BUSOP_WRITEB; req_addr[63:32] = 32'h2003; req_data[63:32] = 32'h000000A5;
    req_en[1] = 1'b1;
    changed = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      @(posedge clk); #1;
      if (grant == 2'b10) begin
        if (!changed) begin
          req_data[63:32] = 32'h0; req_addr[63:32] = 32'hFFFF0000; changed = 1'b1;
        end
        tests++; if (bus_wdata !== 32'hA5 || bus_addr !== 32'h2003 || bus_op !== BUSOP_WRITEB) begin
          fails++; $display("FAIL wr_latched: got %h/%h/%0d exp a5/2003/5", bus_wdata, bus_addr, bus_op);
        end
      end
      if (done[1]) begin seen_done = 1'b1; req_en[1] = 1'b0; end
    end
    tests++; if (!seen_done) begin fails++; $display("FAIL wr_done: got none exp one pulse"); end
  endtask

  task automatic test_async_reset();
    bit seen_done;
    lat = 4; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_op[2:0] = BUSOP_READW; req_addr[31:0] = 32'h300;
    req_en[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (bus_busy !== 1'b1 || grant !== 2'b01) begin
      fails++; $display("FAIL ar_in_wait: got busy=%b grant=%b exp 1/01", bus_busy, grant);
    end
    #2;
    rst_n = 1'b0; req_en = '0;
    #1;
    tests++; if (grant !== 2'b00 || done !== 2'b00 || bus_en !== 1'b0) begin
      fails++; $display("FAIL ar_ctrl_zero: got grant=%b done=%b en=%b exp 0", grant, done, bus_en);
    end
    tests++; if (req_rdata !== 32'h0 || bus_op !== 3'd0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      fails++; $display("FAIL ar_data_zero: got %h/%h/%h/%h exp 0", req_rdata, bus_op, bus_addr, bus_wdata);
    end
    seen_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done != 2'b00) seen_done = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done != 2'b00 || grant != 2'b00) seen_done = 1'b1; end
    tests++; if (seen_done) begin fails++; $display("FAIL ar_no_done: got activity exp none"); end
    bus_rdata = 32'h0BADCAFE; req_addr[31:0] = 32'h400;
    req_en[0] = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      @(posedge clk); #1;
      if (done[0]) begin seen_done = 1'b1; req_en[0] = 1'b0; end
    end
    tests++; if (!seen_done || req_rdata !== 32'h0BADCAFE) begin
      fails++; $display("FAIL ar_fresh: got done=%b data=%h exp 1/0badcafe", seen_done, req_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_write_passthrough();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
